// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, IMEM address bounds, NOP encoding
// and the sequential PC advance rule.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_SKID = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_LAST   = 32'd4092;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] pc_advance(input logic [31:0] pc,
                                             input logic [31:0] pc_last);
    if (pc == pc_last) begin
      return 32'h0000_0000;
    end else begin
      return pc + 32'd4;
    end
  endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// IF/ID holding register plus a one-entry skid that absorbs a memory response
// arriving while decode is stalled.
module if_skid_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        skid_valid
);

  logic        out_valid_r;
  logic [31:0] out_pc_r;
  logic [31:0] out_instr_r;
  logic        skid_valid_r;
  logic [31:0] skid_pc_r;
  logic [31:0] skid_instr_r;

  assign out_valid  = out_valid_r;
  assign out_pc     = out_pc_r;
  assign out_instr  = out_instr_r;
  assign skid_valid = skid_valid_r;

  // IF/ID and skid update; a full skid always drains before new data is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r  <= 1'b0;
      out_pc_r     <= 32'h0000_0000;
      out_instr_r  <= 32'h0000_0000;
      skid_valid_r <= 1'b0;
      skid_pc_r    <= 32'h0000_0000;
      skid_instr_r <= 32'h0000_0000;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (skid_valid_r) begin
      if (!stall) begin
        out_valid_r  <= 1'b1;
        out_pc_r     <= skid_pc_r;
        out_instr_r  <= skid_instr_r;
        skid_valid_r <= 1'b0;
      end
    end else if (in_valid) begin
      if (!out_valid_r || !stall) begin
        out_valid_r <= 1'b1;
        out_pc_r    <= in_pc;
        out_instr_r <= in_instr;
      end else begin
        skid_valid_r <= 1'b1;
        skid_pc_r    <= in_pc;
        skid_instr_r <= in_instr;
      end
    end else if (out_valid_r && !stall) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: single-outstanding requests to instr_mem, IF/ID
// register with skid, branch redirect and sticky misaligned-target flag.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] PC_LAST  = cpu_pkg::PC_LAST
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step_en,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misalign_err
);

  import cpu_pkg::*;

  fetch_state_e state_r;
  fetch_state_e state_nxt_s;
  logic [31:0]  pc_r;
  logic [31:0]  req_pc_r;
  logic         pending_r;
  logic         misalign_r;
  logic         skid_valid_s;
  logic         redirect_s;
  logic         issue_s;
  logic         capture_s;
  logic         to_skid_s;

  assign imem_addr    = pc_r;
  assign misalign_err = misalign_r;

  // Request/response qualifiers; an accepted redirect outranks everything else.
  always_comb begin
    redirect_s = 1'b0;
    issue_s    = 1'b0;
    capture_s  = 1'b0;
    to_skid_s  = 1'b0;
    if (state_r != ST_BOOT) begin
      redirect_s = redirect_valid;
    end else begin
      redirect_s = 1'b0;
    end
    issue_s   = (state_r == ST_RUN) && step_en && !pending_r && !skid_valid_s && !redirect_s;
    capture_s = pending_r && !redirect_s;
    to_skid_s = capture_s && if_valid && stall;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_BOOT: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (redirect_s) begin
          state_nxt_s = ST_RUN;
        end else if (to_skid_s) begin
          state_nxt_s = ST_SKID;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_SKID: begin
        if (redirect_s || !stall) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_SKID;
        end
      end
      default: state_nxt_s = ST_BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // PC, outstanding request tracking and sticky misalignment flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      req_pc_r   <= 32'h0000_0000;
      pending_r  <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      if (redirect_s) begin
        pc_r      <= {redirect_pc[31:2], 2'b00};
        pending_r <= 1'b0;
      end else if (issue_s) begin
        req_pc_r  <= pc_r;
        pending_r <= 1'b1;
        pc_r      <= pc_advance(pc_r, PC_LAST);
      end else begin
        // issue is blocked while pending, so this is the response cycle or idle
        pending_r <= 1'b0;
      end
      if (redirect_s && (redirect_pc[1:0] != 2'b00)) begin
        misalign_r <= 1'b1;
      end
    end
  end

  if_skid_buffer u_skid (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_s),
    .in_valid   (capture_s),
    .in_pc      (req_pc_r),
    .in_instr   (imem_instr),
    .stall      (stall),
    .out_valid  (if_valid),
    .out_pc     (if_pc),
    .out_instr  (if_instr),
    .skid_valid (skid_valid_s)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a behavioural 1-cycle instr_mem and
// an expected-PC queue checked whenever decode consumes an instruction.
module tb_if_fetch_stage;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        step_en = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign_err;

  int          checks = 0;
  int          failures = 0;
  int          cons_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp_pc;
  logic [31:0] mon_prev_pc = 32'hFFFF_FFFF;
  logic        wrap_seen = 1'b0;
  int          first_valid;
  logic [31:0] y;

  always #5 clock = ~clock;

  if_fetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .step_en        (step_en),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .misalign_err   (misalign_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + {20'd0, a[11:2], 2'b00};
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] p);
    return (p == PC_LAST) ? 32'h0000_0000 : p + 32'd4;
  endfunction

  // instr_mem: mem[i] = i*4 + 0xA0000000, one cycle read latency
  always @(posedge clock) imem_instr <= mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    logic [31:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = next_pc(p);
    end
  endtask

  task automatic drain();
    step_en = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    repeat (6) tick();
  endtask

  task automatic wait_cons(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (cons_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, (cons_cnt >= target)}, 32'd1);
  endtask

  // Scoreboard: each instruction taken by decode must be the next expected one.
  always @(negedge clock) begin
    if (!reset && !redirect_valid && if_valid && !stall) begin
      mon_exp_pc = (exp_q.size() != 0) ? exp_q.pop_front() : ~if_pc;
      chk("sb_pc", if_pc, mon_exp_pc);
      chk("sb_instr", if_instr, mem_word(mon_exp_pc));
      if (mon_prev_pc == PC_LAST && if_pc == 32'h0000_0000) wrap_seen = 1'b1;
      mon_prev_pc = if_pc;
      cons_cnt++;
    end
  end

  initial begin
    // Reset values
    repeat (3) tick();
    @(negedge clock);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);

    // Release reset with step_en every cycle; first valid at cycle 3
    exp_q.delete();
    push_stream(RESET_PC, 1100);
    tick();
    reset = 1'b0;
    step_en = 1'b1;
    first_valid = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (if_valid && first_valid < 0) first_valid = c;
      tick();
    end
    chk("first_valid_cycle", first_valid, 32'd3);

    // Run through PC_LAST and wrap to 0
    wait_cons(1026, 2400, "wrap_progress");
    chk("wrap_seen", {31'd0, wrap_seen}, 32'd1);

    // Stall 5 cycles with a response in flight
    drain();
    y = exp_q[0];
    step_en = 1'b1;
    tick();
    tick();
    stall = 1'b1;
    @(negedge clock);
    chk("stall_entry_pc", if_pc, y);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clock);
      chk("stall_pc", if_pc, y);
      chk("stall_instr", if_instr, mem_word(y));
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
    end
    chk("stall_state", {30'd0, dut.state_r}, {30'd0, ST_SKID});
    tick();
    stall = 1'b0;
    tick();
    @(negedge clock);
    chk("unstall_pc", if_pc, next_pc(y));
    chk("unstall_valid", {31'd0, if_valid}, 32'd1);
    wait_cons(cons_cnt + 4, 40, "unstall_progress");

    // Redirect to 0x100 in the response-capture cycle
    drain();
    exp_q.delete();
    push_stream(32'h0000_0100, 50);
    step_en = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("redir_drop_valid", {31'd0, if_valid}, 32'd0);
    chk("redir_misalign", {31'd0, misalign_err}, 32'd0);
    wait_cons(cons_cnt + 4, 40, "redir_progress");

    // Misaligned redirect to 0x102 fetches from 0x100
    drain();
    exp_q.delete();
    push_stream(32'h0000_0100, 50);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    step_en = 1'b1;
    @(negedge clock);
    chk("misalign_set", {31'd0, misalign_err}, 32'd1);
    chk("misalign_addr", imem_addr, 32'h0000_0100);
    wait_cons(cons_cnt + 3, 40, "misalign_progress");

    // Reset while in SKID
    drain();
    step_en = 1'b1;
    tick();
    tick();
    stall = 1'b1;
    tick();
    tick();
    @(negedge clock);
    chk("pre_rst_state", {30'd0, dut.state_r}, {30'd0, ST_SKID});
    chk("misalign_sticky", {31'd0, misalign_err}, 32'd1);
    tick();
    reset = 1'b1;
    exp_q.delete();
    push_stream(RESET_PC, 20);
    tick();
    reset = 1'b0;
    stall = 1'b0;
    @(negedge clock);
    chk("skidrst_valid", {31'd0, if_valid}, 32'd0);
    chk("skidrst_pc", if_pc, 32'd0);
    chk("skidrst_instr", if_instr, 32'd0);
    chk("skidrst_misalign", {31'd0, misalign_err}, 32'd0);
    chk("skidrst_addr", imem_addr, RESET_PC);
    chk("skidrst_state", {30'd0, dut.state_r}, {30'd0, ST_BOOT});
    wait_cons(cons_cnt + 3, 40, "post_rst_progress");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  RESET_PC  32'h0000_0000  first fetch address after reset
  PC_LAST   32'd4092       last word address in IMEM; sequential fetch wraps to 0 after it
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clock          in   1   single clock
  reset          in   1   synchronous, active-high
  step_en        in   1   fetch-advance enable (1-cycle pulse from clock_divider)
  stall          in   1   decode cannot accept; holds if_valid/if_pc/if_instr
  redirect_valid in   1   branch/jump redirect request
  redirect_pc    in   32  redirect target
  imem_addr      out  32  address to instr_mem (pc input)
  imem_instr     in   32  instr_mem data; valid the cycle after imem_addr is sampled
  if_valid       out  1   IF/ID register holds a valid instruction
  if_pc          out  32  PC of if_instr
  if_instr       out  32  fetched instruction
  misalign_err   out  1   sticky; set by a redirect_pc with [1:0] != 0

Function
REQ-003 The FSM SHALL have states BOOT, RUN and SKID.
REQ-004 BOOT: entered on reset; lasts exactly 1 cycle; no issue; next state RUN.
REQ-005 Issue SHALL occur in a cycle where state==RUN, step_en=1, no response pending, skid empty and redirect_valid=0.
REQ-006 imem_addr SHALL equal pc_q combinationally; on issue, the block SHALL record req_pc=pc_q, set pending, and advance pc_q.
REQ-007 pc_q advance: pc_q==PC_LAST -> 0, otherwise pc_q+4; modulo 2^32 arithmetic, no carry out.
REQ-008 Response: one cycle after issue, imem_instr SHALL be captured with req_pc; pending clears.
REQ-009 Capture target: if if_valid==0 or stall==0, load IF/ID (if_valid=1, if_pc=req_pc, if_instr=imem_instr); otherwise load the 1-entry skid and go to SKID.
REQ-010 Latency: if_valid SHALL rise 2 cycles after the issue cycle when not stalled.
REQ-011 Consume: if_valid==1 and stall==0 consumes the entry; IF/ID clears unless it is refilled in the same cycle.
REQ-012 SKID: no issue; when stall==0, skid moves into IF/ID on the next edge; state returns to RUN.
REQ-013 While stall==1, if_valid/if_pc/if_instr SHALL remain stable.
REQ-014 Redirect (any state except BOOT) SHALL, on the next edge:
  - set pc_q={redirect_pc[31:2],2'b00}
  - clear IF/ID valid, skid and pending, discarding any in-flight response
  - set state to RUN
REQ-015 Redirect SHALL override stall, step_en and a simultaneous response capture.
REQ-016 Redirect during BOOT SHALL be ignored.
REQ-017 misalign_err SHALL set on redirect_valid with redirect_pc[1:0]!=0 and clear only on reset.
REQ-018 An instruction SHALL never be dropped or duplicated, except when discarded by a redirect.

Reset
REQ-019 On reset the block SHALL set state=BOOT, pc_q=RESET_PC, pending=0, skid empty, if_valid=0, if_pc=0, if_instr=0 and misalign_err=0.
REQ-020 Reset asserted mid-operation SHALL abandon all in-flight state within the same edge; any imem_instr from before reset SHALL be ignored.

Structure
REQ-021 The FSM state enum, PC_LAST, RESET_PC and the NOP encoding 32'h0000_0013 SHALL live in a shared package, cpu_pkg.
REQ-022 The skid/IF-ID holding logic SHALL be a sub-module named if_skid_buffer (1-entry, valid/stall).
REQ-023 The block SHALL connect directly to the existing instr_mem (clk, pc, instr) and clock_divider clk_en; no other memories SHALL be used.

Verification
REQ-024 The bench SHALL use a behavioural instr_mem model with mem[i]=i*4+32'hA000_0000 and 1-cycle read latency.
REQ-025 The bench SHALL cover the following directed scenarios:
  - Reset then step_en every cycle -> if_valid first at cycle 3 after reset release; if_pc sequence 0,4,8; if_instr A0000000, A0000004, ...
  - Run to pc_q=4092 -> if_pc 4092 followed by 0; no gap or duplicate.
  - stall=1 for 5 cycles with a response in flight -> if_pc/if_instr frozen; state SKID; after release, if_pc increments by 4 on consecutive consumes with no loss.
  - redirect_valid with redirect_pc=32'h100 in the same cycle as a response capture -> in-flight instruction dropped; next if_pc=0x100.
  - redirect_pc=32'h102 -> fetch from 0x100; misalign_err=1 and remains 1 until reset.
  - reset asserted while in SKID -> all outputs return to reset values next cycle; first post-reset if_pc=RESET_PC.
